// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over a 2*XLEN accumulator, valid/ready on both sides.
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_SPECIAL,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                out_valid_q, out_valid_d;

  // Operand decode at the input port
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_in, special_in, accept;

  always_comb begin
    a_signed   = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed   = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    sign_a     = a_signed && rs1[XLEN-1];
    sign_b     = b_signed && rs2[XLEN-1];
    a_mag      = sign_a ? (~rs1 + 1'b1) : rs1;
    b_mag      = sign_b ? (~rs2 + 1'b1) : rs2;
    if (!op[2])
      neg_in = sign_a ^ sign_b;
    else if (!op[1])
      neg_in = (sign_a ^ sign_b) && (rs2 != '0);
    else
      neg_in = sign_a;
    special_in = op[2] && ((rs2 == '0) ||
                 (!op[0] && (rs1 == MOST_NEG) && (rs2 == '1)));
    accept     = in_valid && (state_q == S_IDLE) && !flush;
  end

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_step, div_step, acc_neg;
  logic [XLEN-1:0]   div_pick, fix_val, special_val;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    // A borrow out of the widened remainder means the trial subtract fails
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (!div_diff[XLEN])
      div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      div_step = {acc_q[2*XLEN-2:0], 1'b0};

    // The product is negated as a whole so MULH* high halves stay correct
    acc_neg  = ~acc_q + 1'b1;
    div_pick = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (!op_q[2]) begin
      if (op_q == 3'd0)
        fix_val = neg_q ? acc_neg[XLEN-1:0] : acc_q[XLEN-1:0];
      else
        fix_val = neg_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end else begin
      fix_val = neg_q ? (~div_pick + 1'b1) : div_pick;
    end

    // Divide-by-zero remainder rebuilds rs1 from its magnitude and sign
    if (b_q == '0)
      special_val = op_q[1] ? (neg_q ? (~a_q + 1'b1) : a_q) : '1;
    else
      special_val = op_q[1] ? '0 : MOST_NEG;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op;
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = neg_in;
          acc_d   = op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          cnt_d   = '0;
          state_d = special_in ? S_SPECIAL : S_CALC;
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      S_SPECIAL: begin
        result_d = special_val;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect abandons the operation without touching the result
    if (flush && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: all eight ops, special cases, latency,
// backpressure, flush, async reset, and an XLEN=8 instance.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, result;

  logic        v8_in_valid, v8_in_ready, v8_flush, v8_out_valid, v8_out_ready, v8_busy;
  logic [2:0]  v8_op;
  logic [7:0]  v8_rs1, v8_rs2, v8_result;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  muldiv_unit #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .op(v8_op), .rs1(v8_rs1), .rs2(v8_rs2), .flush(v8_flush), .out_valid(v8_out_valid),
    .out_ready(v8_out_ready), .result(v8_result), .busy(v8_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the result, check latency/value, handshake it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold, input bit poke);
    int n;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = !hold;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rs1 = ~a; rs2 = ~b; op = o ^ 3'd1;
    n = 0;
    while (!out_valid && n < 200) begin
      if (poke && n == 3) begin
        in_valid = 1'b1; op = 3'd0; rs1 = 32'd123; rs2 = 32'd456;
      end
      if (poke && n == 6) in_valid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp));
    $display("op=%0d rs1=0x%08h rs2=0x%08h result=0x%08h latency=%0d (%s)", o, a, b, result, n, tag);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_result"}, 64'(result), 64'(exp));
        check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] prev;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = 3'd0; rs1 = '0; rs2 = '0;
    v8_in_valid = 1'b0; v8_flush = 1'b0; v8_out_ready = 1'b1;
    v8_op = 3'd0; v8_rs1 = '0; v8_rs2 = '0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_neg",    3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 34, 0, 0);
    run_op("mul_zero",   3'd0, 32'd0,        32'h12345678, 32'd0,        34, 0, 0);
    run_op("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0, 0);
    run_op("mulh_m1x1",  3'd1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, 0, 0);
    run_op("mulhsu",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0, 0);
    run_op("mulhu",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0, 0);
    run_op("div_poke",   3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0, 1);
    run_op("rem_neg",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0, 0);
    run_op("divu_hold",  3'd5, 32'd100,      32'd7,        32'd14,       34, 1, 0);
    run_op("remu",       3'd7, 32'd100,      32'd7,        32'd2,        34, 0, 0);
    run_op("divu_by0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  0, 0);
    run_op("div_by0",    3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 2,  0, 0);
    run_op("rem_by0",    3'd6, 32'd5,        32'd0,        32'd5,        2,  0, 0);
    run_op("rem_neg_by0",3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2,  0, 0);
    run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  0, 0);
    run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  0, 0);

    // Flush at CALC cycle 10
    prev = 32'd0;
    op = 3'd0; rs1 = 32'h1234; rs2 = 32'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    check("flush_result_kept", 64'(result), 64'(prev));
    $display("flush during CALC: out_valid_seen=%0d result=0x%08h", seen, result);
    run_op("mul_after_flush", 3'd0, 32'd6, 32'd7, 32'd42, 34, 0, 0);

    // Asynchronous reset at CALC cycle 5
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_in_ready", 64'(in_ready), 64'd1);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_out_valid", 64'(out_valid), 64'd0);
    check("areset_result", 64'(result), 64'd0);
    $display("async reset mid-CALC: in_ready=%0d busy=%0d result=0x%08h", in_ready, busy, result);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("remu_after_reset", 3'd7, 32'd100, 32'd7, 32'd2, 34, 0, 0);

    // XLEN=8 corner
    check("x8_in_ready", 64'(v8_in_ready), 64'd1);
    v8_op = 3'd3; v8_rs1 = 8'hFF; v8_rs2 = 8'hFF; v8_in_valid = 1'b1;
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    n = 0;
    while (!v8_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("x8_mulhu_latency", 64'(n), 64'd10);
    check("x8_mulhu_result", 64'(v8_result), 64'h00FE);
    $display("XLEN=8 op=3 rs1=0xff rs2=0xff result=0x%02h latency=%0d", v8_result, n);
    @(posedge clk); #1;
    check("x8_after_hs", 64'(v8_in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
